// File: rtl/rv32ic_fetch_pkg.sv
// rv32ic_fetch_pkg
//   Constants and helpers shared by the fetch-side aligner and the
//   decompressor of the RV32IC core.
//   HW_W   : width of one instruction halfword
//   WORD_W : width of one fetch word
//   QDEPTH : depth of the aligner's halfword queue
package rv32ic_fetch_pkg;

    localparam int HW_W   = 16;
    localparam int WORD_W = 32;
    localparam int QDEPTH = 4;

    typedef logic [HW_W-1:0] hw_t;

    // A halfword starts a 16-bit instruction unless its two low bits are 11.
    function automatic logic is_compressed(input hw_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// fetch_hw_queue
//   4-entry halfword shift queue. Entry 0 is the head. Each cycle the
//   queue first drops pop_n halfwords from the head, then appends push_n
//   halfwords behind the survivors (push_data[15:0] first, then [31:16]).
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     clear      : drop all entries (flush)
//     push_n     : halfwords to append (0/1/2)
//     pop_n      : halfwords to remove from the head (0/1/2)
//     push_data  : halfwords to append, low half first
//     entry0/1   : the two head entries
//     count      : number of valid entries (0..4)
//   The caller guarantees pop_n <= count and count - pop_n + push_n <= 4.
module fetch_hw_queue
    import rv32ic_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [1:0]        push_n,
    input  logic [1:0]        pop_n,
    input  logic [WORD_W-1:0] push_data,
    output logic [HW_W-1:0]   entry0,
    output logic [HW_W-1:0]   entry1,
    output logic [2:0]        count
);

    localparam int QBITS = QDEPTH * HW_W;

    logic [QDEPTH-1:0][HW_W-1:0] q;
    logic [QDEPTH-1:0][HW_W-1:0] q_next;
    logic [2:0]                  base;
    logic [2:0]                  count_next;
    logic [WORD_W-1:0]           push_bits;
    logic [QBITS-1:0]            ins;

    // Entries at or beyond count are always zero, so the shifted queue and
    // the appended halfwords can simply be OR-ed together.
    always_comb begin
        push_bits  = '0;
        base       = count - {1'b0, pop_n};
        count_next = base + {1'b0, push_n};
        case (push_n)
            2'd1:    push_bits = {{HW_W{1'b0}}, push_data[HW_W-1:0]};
            2'd2:    push_bits = push_data;
            default: push_bits = '0;
        endcase
        ins    = {{(QBITS-WORD_W){1'b0}}, push_bits} << (int'(base) * HW_W);
        q_next = (q >> (int'(pop_n) * HW_W)) | ins;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q     <= '0;
            count <= '0;
        end else begin
            q     <= q_next;
            count <= count_next;
        end
    end

    assign entry0 = q[0];
    assign entry1 = q[1];

endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner
//   Splits the word-aligned fetch stream into 16-bit compressed and 32-bit
//   instructions, including 32-bit instructions straddling two words, and
//   tracks the PC of each emitted instruction.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     flush       : redirect; drops buffered halfwords, reloads head PC
//     flush_pc    : new head PC (bit 0 ignored)
//     in_data     : fetch word, in_valid / in_ready handshake
//     instr       : aligned instruction (compressed ones zero-extended)
//     instr_pc    : PC of instr
//     instr_c     : instr is 16-bit
//     out_valid / out_ready : output handshake
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1 (and flush is 0). valid never depends on ready; in_ready and
//   all output-side signals come from registered state only, so there is no
//   combinational path from in_* to out_*.
module fetch_aligner
    import rv32ic_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_c,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [31:0]     head_pc;
    logic            skip_low;
    logic [HW_W-1:0] entry0;
    logic [HW_W-1:0] entry1;
    logic [2:0]      count;
    logic            head_c;
    logic            push_fire;
    logic            pop_fire;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    logic [WORD_W-1:0] push_data;

    always_comb begin
        head_c    = is_compressed(entry0);
        out_valid = (head_c && count >= 3'd1) || (!head_c && count >= 3'd2);
        in_ready  = (count <= 3'd2);
        push_fire = in_valid && in_ready && !flush;
        pop_fire  = out_valid && out_ready && !flush;
        push_n    = push_fire ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
        pop_n     = pop_fire ? (head_c ? 2'd1 : 2'd2) : 2'd0;
        // After a redirect to a PC with bit 1 set, the low half of the first
        // word lies before the target and is dropped.
        push_data = {in_data[31:16], skip_low ? in_data[31:16] : in_data[15:0]};
        // Outputs are forced to zero when nothing valid is presented so the
        // idle queue content never leaks out.
        instr     = '0;
        instr_c   = 1'b0;
        if (out_valid) begin
            instr   = head_c ? {16'h0000, entry0} : {entry1, entry0};
            instr_c = head_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc  <= RESET_PC;
            skip_low <= RESET_PC[1];
        end else if (flush) begin
            head_pc  <= flush_pc & ~32'h1;
            skip_low <= flush_pc[1];
        end else begin
            if (pop_fire) begin
                head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
            end
            if (push_fire) begin
                skip_low <= 1'b0;
            end
        end
    end

    fetch_hw_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push_n    (push_n),
        .pop_n     (pop_n),
        .push_data (push_data),
        .entry0    (entry0),
        .entry1    (entry1),
        .count     (count)
    );

    assign instr_pc = head_pc;

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_c;
    logic        out_valid;
    logic        out_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .instr_pc  (instr_pc),
        .instr_c   (instr_c),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_c);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".instr"}, instr, e_instr);
        check({tag, ".pc"}, instr_pc, e_pc);
        check({tag, ".c"}, {31'd0, instr_c}, {31'd0, e_c});
    endtask

    initial begin
        flush_pc = '0;
        in_data  = '0;
        #2;
        do_reset();

        // reset state
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.instr", instr, 32'd0);
        check("rst.c", {31'd0, instr_c}, 32'd0);
        check("rst.pc", instr_pc, 32'd0);

        // two aligned 32-bit instructions back to back
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0513;
        tick();
        expect_out("w32a", 32'h0000_0513, 32'h0, 1'b0);
        in_data = 32'h0010_0093;
        tick();
        expect_out("w32b", 32'h0010_0093, 32'h4, 1'b0);
        in_valid = 1'b0;
        tick();
        check("w32.drain", {31'd0, out_valid}, 32'd0);
        check("w32.pc_end", instr_pc, 32'h8);

        // two compressed instructions in one word
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h4505_4501;
        tick();
        in_valid = 1'b0;
        expect_out("c2a", 32'h0000_4501, 32'h0, 1'b1);
        tick();
        expect_out("c2b", 32'h0000_4505, 32'h2, 1'b1);
        tick();
        check("c2.drain", {31'd0, out_valid}, 32'd0);

        // 32-bit instruction straddling a word boundary
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0513_4501;
        tick();
        in_valid = 1'b0;
        expect_out("str.cli", 32'h0000_4501, 32'h0, 1'b1);
        tick();
        check("str.wait1", {31'd0, out_valid}, 32'd0);
        check("str.wait_pc", instr_pc, 32'h2);
        tick();
        check("str.wait2", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hAAAA_0000;
        tick();
        in_valid = 1'b0;
        expect_out("str.w32", 32'h0000_0513, 32'h2, 1'b0);
        tick();
        expect_out("str.tail", 32'h0000_AAAA, 32'h6, 1'b1);

        // flush with three halfwords buffered
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h0513_4501;
        tick();
        out_ready = 1'b1;
        in_data   = 32'h0000_0000;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expect_out("fl.pre", 32'h0000_0513, 32'h2, 1'b0);
        flush     = 1'b1;
        flush_pc  = 32'h0000_0102;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl.valid", {31'd0, out_valid}, 32'd0);
        check("fl.in_ready", {31'd0, in_ready}, 32'd1);
        check("fl.pc", instr_pc, 32'h102);
        in_valid = 1'b1;
        in_data  = 32'h4585_FFFF;
        tick();
        in_valid = 1'b0;
        expect_out("fl.first", 32'h0000_4585, 32'h102, 1'b1);
        tick();
        check("fl.drain", {31'd0, out_valid}, 32'd0);
        check("fl.pc_end", instr_pc, 32'h104);

        // backpressure with in_valid held high
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h4505_4501;
        tick();
        expect_out("bp.c1", 32'h0000_4501, 32'h0, 1'b1);
        check("bp.rdy1", {31'd0, in_ready}, 32'd1);
        in_data = 32'h0010_0093;
        tick();
        in_data = 32'h0020_0113;
        for (int k = 0; k < 3; k++) begin
            expect_out("bp.hold", 32'h0000_4501, 32'h0, 1'b1);
            check("bp.rdy_low", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        expect_out("bp.c2", 32'h0000_4505, 32'h2, 1'b1);
        check("bp.rdy_c3", {31'd0, in_ready}, 32'd0);
        tick();
        expect_out("bp.w1", 32'h0010_0093, 32'h4, 1'b0);
        check("bp.rdy_c2", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        expect_out("bp.w2", 32'h0020_0113, 32'h8, 1'b0);
        tick();
        check("bp.drain", {31'd0, out_valid}, 32'd0);
        check("bp.pc_end", instr_pc, 32'hC);

        // reset mid-stream with two halfwords buffered
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'h0000_0513;
        tick();
        in_valid = 1'b0;
        expect_out("mr.pre", 32'h0000_0513, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr.valid", {31'd0, out_valid}, 32'd0);
        check("mr.pc", instr_pc, 32'h0);
        check("mr.in_ready", {31'd0, in_ready}, 32'd1);
        check("mr.instr", instr, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mr.stale", {31'd0, out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
# fetch_aligner

Fetch-side instruction aligner for the RV32IC core. It takes the stream of word-aligned 32-bit fetch words from instruction memory and splits it into individual 16-bit compressed or 32-bit instructions. It handles instructions that straddle word boundaries, and it tracks the PC of each instruction it emits. It sits between the fetch unit and the decompressor/decode stage, and performs the inverse of the halfword-select multiplexing used elsewhere in the datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, head PC after reset; must be halfword-aligned.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  redirect (branch/jump/trap); discards all buffered halfwords.
- flush_pc  input  32  new head PC; bit 0 is ignored.
- in_data  input  32  fetch word containing the next sequential word address.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  aligner can accept a word this cycle.
- instr  output  32  aligned instruction; compressed instructions appear zero-extended in [15:0].
- instr_pc  output  32  PC of instr.
- instr_c  output  1  instr is 16-bit (instr[1:0] != 2'b11).
- out_valid  output  1  instr, instr_pc and instr_c are valid.
- out_ready  input  1  consumer accepts instr.

## Operation
Buffer:
- Halfword queue, 4 entries.
- count ranges 0..4.
- Entry 0 is the head; head_pc is the PC of entry 0.

Push (in_valid && in_ready && !flush):
- Normally push 2 halfwords: low half first, then high half.
- If skip_low=1, push only in_data[31:16], then clear skip_low.

Emission rules:
- Head is compressed (head[1:0] != 2'b11) and count >= 1: out_valid=1, instr={16'h0, head}, instr_c=1.
- Head is not compressed and count >= 2: out_valid=1, instr={entry1, entry0}, instr_c=0.
- Otherwise out_valid=0.

Pop (out_valid && out_ready && !flush):
- Remove 1 halfword (compressed) or 2 halfwords (32-bit).
- head_pc += 2 or += 4; wraps modulo 2^32.

Flow control:
- in_ready = (count <= 2), derived from registered state only.
- Push and pop in the same cycle are legal. The next count is count + pushed − popped.
- Entries shift toward the head by the number popped before the pushed halfwords are appended.

Flush:
- Has priority over push and pop in the same cycle; both are ignored.
- Sets count=0, head_pc={flush_pc[31:1],1'b0}, skip_low=flush_pc[1].
- The next word the fetch unit supplies must be from address flush_pc & ~3.

Reset state:
- count=0, head_pc=RESET_PC, skip_low=RESET_PC[1].
- Outputs after reset: out_valid=0, in_ready=1, instr=0, instr_c=0, instr_pc=RESET_PC.

Illegal encodings are not checked here. They pass through to decode.

## Timing
- No combinational path from in_* to out_*. A word accepted in cycle N is visible at the output in cycle N+1 at the earliest.
- instr, instr_pc, instr_c and out_valid are decoded from registers. They may only change after a clock edge.
- out_valid and the outputs hold stable while out_ready=0.
- Throughput: one instruction per cycle whenever the buffer holds a complete instruction. Sustained 32-bit-aligned code sees no bubbles at in_valid=1 and out_ready=1.
- Straddling 32-bit instruction:
  - The instruction occupies entry 0 with count=1; out_valid stays 0 until the next word is pushed.
  - It is emitted the cycle after that push.
- flush and rst take effect at the clock edge where they are sampled. In the following cycle out_valid=0 and in_ready=1.
- rst asserted mid-operation drops all buffered data. No partial instruction is emitted.

## Structure
- Shared package rv32ic_fetch_pkg:
  - HW_W=16, WORD_W=32, QDEPTH=4 constants.
  - is_compressed(hw) function returning hw[1:0] != 2'b11.
  - Shared by the decompressor.
- One sub-module: fetch_hw_queue.
  - Owns the 4-entry halfword shift queue and count.
  - Inputs: push count (0/1/2), pop count (0/1/2), clear.
- fetch_aligner owns head_pc, skip_low, the emission decode and the handshakes.

## Test plan
- Reset with RESET_PC=0, then push 32'h0000_0513 and 32'h0010_0093 with out_ready=1:
  - instr=32'h0000_0513 at pc 0.
  - Next cycle instr=32'h0010_0093 at pc 4, instr_c=0.
- Push word 32'h4505_4501 (two c.li):
  - Emits 32'h0000_4501 at pc 0 with instr_c=1.
  - Then 32'h0000_4505 at pc 2 with instr_c=1.
- Straddle case: push 32'h0513_4501, then 32'hAAAA_0000:
  - First emit c.li at pc 0.
  - The 32'h0000_0513 instruction at pc 2 appears only after the second push.
- Flush to flush_pc=32'h0000_0102 while count=3:
  - Next cycle out_valid=0, in_ready=1.
  - Push 32'h4585_FFFF: emits 32'h0000_4585 at pc 0x102; the 0xFFFF half is discarded.
- Backpressure: hold out_ready=0 with in_valid=1 continuously:
  - in_ready drops after count reaches 3 or 4.
  - instr and instr_pc are stable every cycle.
  - Releasing out_ready drains in order with no loss.
- Assert rst mid-stream with count=2:
  - Next cycle out_valid=0, instr_pc=RESET_PC.
  - No stale instruction appears afterward.
